// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch/jump flush, multi-cycle MDU
// stall and memory-wait freeze, with saturating stall/flush statistics.
module pipeline_hazard_ctrl #(
   parameter int MDU_CYCLES = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic        ex_mem_read,
   input  logic [4:0]  ex_rt,
   input  logic        ex_branch_taken,
   input  logic        id_jump,
   input  logic        mdu_start,
   input  logic        mem_wait,
   output logic        pc_write,
   output logic        if_id_load,
   output logic        if_id_flush,
   output logic        id_ex_bubble,
   output logic        id_ex_hold,
   output logic        ex_mem_bubble,
   output logic        ex_mem_hold,
   output logic        mdu_busy,
   output logic [15:0] stall_cycles,
   output logic [7:0]  flush_count
);

   typedef enum logic {RUN, MDU_WAIT} state_t;

   typedef struct packed {
      logic pc_write;
      logic if_id_load;
      logic if_id_flush;
      logic id_ex_bubble;
      logic id_ex_hold;
      logic ex_mem_bubble;
      logic ex_mem_hold;
   } ctl_t;

   localparam ctl_t CTL_OFF  = '0;
   localparam ctl_t CTL_RUN  = '{pc_write: 1'b1, if_id_load: 1'b1, default: 1'b0};
   localparam ctl_t CTL_FRZ  = '{id_ex_hold: 1'b1, ex_mem_hold: 1'b1, default: 1'b0};
   localparam ctl_t CTL_MDU  = '{id_ex_hold: 1'b1, ex_mem_bubble: 1'b1, default: 1'b0};
   localparam ctl_t CTL_BR   = '{pc_write: 1'b1, if_id_flush: 1'b1, id_ex_bubble: 1'b1, default: 1'b0};
   localparam ctl_t CTL_LU   = '{id_ex_bubble: 1'b1, default: 1'b0};
   localparam ctl_t CTL_JMP  = '{pc_write: 1'b1, if_id_flush: 1'b1, default: 1'b0};

   localparam logic [3:0] CNT_INIT = 4'(MDU_CYCLES - 1);

   state_t     state, state_nxt;
   logic [3:0] cnt, cnt_nxt;
   ctl_t       ctl;
   logic       load_use;

   assign load_use = ex_mem_read & (ex_rt != 5'd0) & ((ex_rt == id_rs) | (ex_rt == id_rt));

   // Pipeline registers update on the falling edge; this block follows suit.
   always_ff @(negedge clk or negedge reset) begin
      if (!reset) begin
         state <= RUN;
         cnt   <= 4'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      if (!mem_wait) begin
         case (state)
            RUN: begin
               if (!ex_branch_taken && mdu_start) begin
                  state_nxt = MDU_WAIT;
                  cnt_nxt   = CNT_INIT;
               end
            end
            MDU_WAIT: begin
               if (cnt <= 4'd1) begin
                  state_nxt = RUN;
                  cnt_nxt   = 4'd0;
               end else begin
                  cnt_nxt = cnt - 4'd1;
               end
            end
            default: begin
               state_nxt = RUN;
               cnt_nxt   = 4'd0;
            end
         endcase
      end
   end

   always_comb begin
      ctl = CTL_RUN;
      if (!reset)                 ctl = CTL_OFF;
      else if (mem_wait)          ctl = CTL_FRZ;
      else if (state == MDU_WAIT) ctl = CTL_MDU;
      else if (ex_branch_taken)   ctl = CTL_BR;
      else if (mdu_start)         ctl = CTL_MDU;
      else if (load_use)          ctl = CTL_LU;
      else if (id_jump)           ctl = CTL_JMP;
   end

   assign pc_write      = ctl.pc_write;
   assign if_id_load    = ctl.if_id_load;
   assign if_id_flush   = ctl.if_id_flush;
   assign id_ex_bubble  = ctl.id_ex_bubble;
   assign id_ex_hold    = ctl.id_ex_hold;
   assign ex_mem_bubble = ctl.ex_mem_bubble;
   assign ex_mem_hold   = ctl.ex_mem_hold;
   assign mdu_busy      = (state == MDU_WAIT);

   always_ff @(negedge clk or negedge reset) begin
      if (!reset) begin
         stall_cycles <= 16'd0;
         flush_count  <= 8'd0;
      end else begin
         if (!ctl.pc_write && stall_cycles != 16'hFFFF) stall_cycles <= stall_cycles + 16'd1;
         if (ctl.if_id_flush && flush_count != 8'hFF)   flush_count  <= flush_count + 8'd1;
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; control outputs are compared as one
// 7-bit vector {pc_write,if_id_load,if_id_flush,id_ex_bubble,id_ex_hold,ex_mem_bubble,ex_mem_hold}.
module tb_pipeline_hazard_ctrl;

   localparam logic [6:0] E_OFF = 7'b0000000;
   localparam logic [6:0] E_DEF = 7'b1100000;
   localparam logic [6:0] E_FRZ = 7'b0000101;
   localparam logic [6:0] E_MDU = 7'b0000110;
   localparam logic [6:0] E_BR  = 7'b1011000;
   localparam logic [6:0] E_LU  = 7'b0001000;
   localparam logic [6:0] E_JMP = 7'b1010000;

   logic        clk = 1'b1;
   logic        reset;
   logic [4:0]  id_rs, id_rt, ex_rt;
   logic        ex_mem_read, ex_branch_taken, id_jump, mdu_start, mem_wait;
   logic        pc_write, if_id_load, if_id_flush, id_ex_bubble, id_ex_hold;
   logic        ex_mem_bubble, ex_mem_hold, mdu_busy;
   logic [15:0] stall_cycles;
   logic [7:0]  flush_count;
   logic [6:0]  ctl;

   int errors = 0;
   int checks = 0;
   int exp_stall = 0;
   int exp_flush = 0;

   always #5 clk = ~clk;

   assign ctl = {pc_write, if_id_load, if_id_flush, id_ex_bubble, id_ex_hold, ex_mem_bubble, ex_mem_hold};

   pipeline_hazard_ctrl #(.MDU_CYCLES(4)) dut (
      .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .ex_mem_read(ex_mem_read),
      .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken), .id_jump(id_jump),
      .mdu_start(mdu_start), .mem_wait(mem_wait), .pc_write(pc_write),
      .if_id_load(if_id_load), .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
      .id_ex_hold(id_ex_hold), .ex_mem_bubble(ex_mem_bubble), .ex_mem_hold(ex_mem_hold),
      .mdu_busy(mdu_busy), .stall_cycles(stall_cycles), .flush_count(flush_count)
   );

   task automatic idle();
      id_rs = 5'd1; id_rt = 5'd2; ex_rt = 5'd3;
      ex_mem_read = 0; ex_branch_taken = 0; id_jump = 0; mdu_start = 0; mem_wait = 0;
   endtask

   // Advance past one falling edge and settle.
   task automatic step();
      @(negedge clk); #1;
   endtask

   task automatic test_reset();
      idle();
      reset = 0;
      #1;
      checks++; if (ctl !== E_OFF) begin errors++; $display("FAIL reset_ctl got=%b exp=%b", ctl, E_OFF); end
      checks++; if (stall_cycles !== 16'd0 || flush_count !== 8'd0 || mdu_busy !== 1'b0) begin
         errors++; $display("FAIL reset_cnt got=%0d/%0d/%b exp=0/0/0", stall_cycles, flush_count, mdu_busy); end
      step(); step();
      #2 reset = 1;
      #1;
      checks++; if (ctl !== E_DEF) begin errors++; $display("FAIL reset_release got=%b exp=%b", ctl, E_DEF); end
      exp_stall = 0; exp_flush = 0;
   endtask

   task automatic test_load_use();
      step();
      ex_mem_read = 1; ex_rt = 5'd8; id_rs = 5'd8; #1;
      checks++; if (ctl !== E_LU) begin errors++; $display("FAIL lu_rs got=%b exp=%b", ctl, E_LU); end
      step(); exp_stall++;
      idle(); #1;
      checks++; if (ctl !== E_DEF) begin errors++; $display("FAIL lu_one_cycle got=%b exp=%b", ctl, E_DEF); end
      checks++; if (stall_cycles !== 16'(exp_stall)) begin errors++; $display("FAIL lu_stall got=%0d exp=%0d", stall_cycles, exp_stall); end
      ex_mem_read = 1; ex_rt = 5'd5; id_rt = 5'd5; #1;
      checks++; if (ctl !== E_LU) begin errors++; $display("FAIL lu_rt got=%b exp=%b", ctl, E_LU); end
      step(); exp_stall++;
      idle();
      ex_mem_read = 1; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0; #1;
      checks++; if (ctl !== E_DEF) begin errors++; $display("FAIL lu_r0 got=%b exp=%b", ctl, E_DEF); end
      step();
      idle(); #1;
      checks++; if (stall_cycles !== 16'(exp_stall)) begin errors++; $display("FAIL lu_r0_stall got=%0d exp=%0d", stall_cycles, exp_stall); end
   endtask

   task automatic test_mdu();
      mdu_start = 1; #1;
      checks++; if (ctl !== E_MDU || mdu_busy !== 1'b0) begin errors++; $display("FAIL mdu_start got=%b/%b exp=%b/0", ctl, mdu_busy, E_MDU); end
      step(); exp_stall++;
      mdu_start = 0;
      for (int i = 0; i < 3; i++) begin
         ex_branch_taken = (i == 1); #1;
         checks++; if (ctl !== E_MDU || mdu_busy !== 1'b1) begin errors++; $display("FAIL mdu_wait%0d got=%b/%b exp=%b/1", i, ctl, mdu_busy, E_MDU); end
         step(); exp_stall++;
      end
      idle(); #1;
      checks++; if (ctl !== E_DEF || mdu_busy !== 1'b0) begin errors++; $display("FAIL mdu_done got=%b/%b exp=%b/0", ctl, mdu_busy, E_DEF); end
      checks++; if (stall_cycles !== 16'(exp_stall) || flush_count !== 8'(exp_flush)) begin
         errors++; $display("FAIL mdu_counts got=%0d/%0d exp=%0d/%0d", stall_cycles, flush_count, exp_stall, exp_flush); end
   endtask

   task automatic test_branch();
      ex_branch_taken = 1; id_jump = 1; mdu_start = 1;
      ex_mem_read = 1; ex_rt = 5'd9; id_rs = 5'd9; #1;
      checks++; if (ctl !== E_BR) begin errors++; $display("FAIL branch got=%b exp=%b", ctl, E_BR); end
      step(); exp_flush++;
      idle(); #1;
      checks++; if (ctl !== E_DEF || mdu_busy !== 1'b0) begin errors++; $display("FAIL branch_after got=%b/%b exp=%b/0", ctl, mdu_busy, E_DEF); end
      checks++; if (flush_count !== 8'(exp_flush) || stall_cycles !== 16'(exp_stall)) begin
         errors++; $display("FAIL branch_counts got=%0d/%0d exp=%0d/%0d", flush_count, stall_cycles, exp_flush, exp_stall); end
   endtask

   task automatic test_jump();
      id_jump = 1; #1;
      checks++; if (ctl !== E_JMP) begin errors++; $display("FAIL jump got=%b exp=%b", ctl, E_JMP); end
      step(); exp_flush++;
      ex_mem_read = 1; ex_rt = 5'd4; id_rt = 5'd4; #1;
      checks++; if (ctl !== E_LU) begin errors++; $display("FAIL jump_lu got=%b exp=%b", ctl, E_LU); end
      step(); exp_stall++;
      ex_mem_read = 0; #1;
      checks++; if (ctl !== E_JMP) begin errors++; $display("FAIL jump_retry got=%b exp=%b", ctl, E_JMP); end
      step(); exp_flush++;
      idle(); #1;
      checks++; if (flush_count !== 8'(exp_flush) || stall_cycles !== 16'(exp_stall)) begin
         errors++; $display("FAIL jump_counts got=%0d/%0d exp=%0d/%0d", flush_count, stall_cycles, exp_flush, exp_stall); end
   endtask

   task automatic test_mem_wait();
      mem_wait = 1; id_jump = 1; #1;
      checks++; if (ctl !== E_FRZ) begin errors++; $display("FAIL memwait_run got=%b exp=%b", ctl, E_FRZ); end
      step(); exp_stall++;
      idle();
      mdu_start = 1; step(); exp_stall++;
      mdu_start = 0; step(); exp_stall++;   // now MDU_WAIT with cnt=2
      for (int i = 0; i < 3; i++) begin
         mem_wait = 1; ex_branch_taken = (i == 0); #1;
         checks++; if (ctl !== E_FRZ || mdu_busy !== 1'b1) begin errors++; $display("FAIL memwait_mdu%0d got=%b/%b exp=%b/1", i, ctl, mdu_busy, E_FRZ); end
         step(); exp_stall++;
      end
      idle();
      for (int i = 0; i < 2; i++) begin
         #1;
         checks++; if (ctl !== E_MDU || mdu_busy !== 1'b1) begin errors++; $display("FAIL memwait_resume%0d got=%b/%b exp=%b/1", i, ctl, mdu_busy, E_MDU); end
         step(); exp_stall++;
      end
      #1;
      checks++; if (ctl !== E_DEF || mdu_busy !== 1'b0) begin errors++; $display("FAIL memwait_done got=%b/%b exp=%b/0", ctl, mdu_busy, E_DEF); end
      checks++; if (stall_cycles !== 16'(exp_stall)) begin errors++; $display("FAIL memwait_stall got=%0d exp=%0d", stall_cycles, exp_stall); end
   endtask

   task automatic test_saturation();
      mem_wait = 1;
      for (int i = 0; i < 70000; i++) step();
      idle(); #1;
      checks++; if (stall_cycles !== 16'hFFFF) begin errors++; $display("FAIL stall_sat got=%h exp=ffff", stall_cycles); end
      id_jump = 1;
      for (int i = 0; i < 300; i++) step();
      idle(); #1;
      checks++; if (flush_count !== 8'hFF) begin errors++; $display("FAIL flush_sat got=%h exp=ff", flush_count); end
      step();
      #2 reset = 0; #1;
      checks++; if (stall_cycles !== 16'd0 || flush_count !== 8'd0 || ctl !== E_OFF) begin
         errors++; $display("FAIL async_reset got=%0d/%0d/%b exp=0/0/%b", stall_cycles, flush_count, ctl, E_OFF); end
      #3 reset = 1;
   endtask

   task automatic test_reset_mid_mdu();
      step();
      mdu_start = 1; step();
      mdu_start = 0; step();   // in MDU_WAIT, cnt=2
      #2 reset = 0; #1;
      checks++; if (mdu_busy !== 1'b0 || ctl !== E_OFF) begin errors++; $display("FAIL mdu_abort got=%b/%b exp=0/%b", mdu_busy, ctl, E_OFF); end
      #2 reset = 1; #1;
      checks++; if (ctl !== E_DEF) begin errors++; $display("FAIL mdu_abort_run got=%b exp=%b", ctl, E_DEF); end
      step();
      checks++; if (ctl !== E_DEF || mdu_busy !== 1'b0 || stall_cycles !== 16'd0) begin
         errors++; $display("FAIL mdu_abort_edge got=%b/%b/%0d exp=%b/0/0", ctl, mdu_busy, stall_cycles, E_DEF); end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_mdu();
      test_branch();
      test_jump();
      test_mem_wait();
      test_saturation();
      test_reset_mid_mdu();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
